// File: rtl/sio_rx_asm.sv
// rtl/sio_rx_asm.sv - L2 bank return stream packet assembler with a small packet FIFO
module sio_rx_asm #(
  parameter int DEPTH = 2,
  parameter int BEATS = 16
) (
  input  logic                  gclk,
  input  logic                  rst_por_,
  input  logic                  l2b_sio_ctag_vld,
  input  logic [31:0]           l2b_sio_data,
  input  logic [1:0]            l2b_sio_parity,
  input  logic                  l2b_sio_ue_err,
  input  logic                  pkt_rdy,
  output logic                  pkt_vld,
  output logic [31:0]           pkt_ctag,
  output logic [32*BEATS-1:0]   pkt_data,
  output logic                  pkt_is_rd,
  output logic                  pkt_ue,
  output logic                  pkt_par_err,
  output logic                  ovfl_err,
  output logic                  proto_err,
  output logic                  rx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, DATA} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_cnt;
  logic            last_beat;
  logic            beat_perr;

  logic [31:0]         stg_ctag;
  logic [32*BEATS-1:0] stg_data;
  logic                stg_rd, stg_ue, stg_par;
  logic                commit_q;

  logic [31:0]         mem_ctag [DEPTH];
  logic [32*BEATS-1:0] mem_data [DEPTH];
  logic                mem_rd   [DEPTH];
  logic                mem_ue   [DEPTH];
  logic                mem_par  [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, pop, push;

  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign beat_perr = (l2b_sio_parity[1] ^ (^l2b_sio_data[31:16])) |
                     (l2b_sio_parity[0] ^ (^l2b_sio_data[15:0]));

  always_ff @(posedge gclk or negedge rst_por_) begin
    if (!rst_por_) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (l2b_sio_ctag_vld && l2b_sio_data[16]) state_d = DATA;
      DATA: begin
        if (l2b_sio_ctag_vld)  state_d = l2b_sio_data[16] ? DATA : IDLE;
        else if (last_beat)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A header always restarts staging, even mid-packet; the stale partial is simply overwritten.
  always_ff @(posedge gclk or negedge rst_por_) begin
    if (!rst_por_) begin
      stg_ctag  <= '0;
      stg_data  <= '0;
      stg_rd    <= 1'b0;
      stg_ue    <= 1'b0;
      stg_par   <= 1'b0;
      commit_q  <= 1'b0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else if (l2b_sio_ctag_vld) begin
      stg_ctag <= l2b_sio_data;
      stg_data <= '0;
      stg_rd   <= l2b_sio_data[16];
      stg_ue   <= 1'b0;
      stg_par  <= beat_perr;
      beat_cnt <= '0;
      commit_q <= ~l2b_sio_data[16];
      if (state_q == DATA) proto_err <= 1'b1;
    end else if (state_q == DATA) begin
      stg_data[{beat_cnt, 5'b0} +: 32] <= l2b_sio_data;
      stg_ue   <= stg_ue | l2b_sio_ue_err;
      stg_par  <= stg_par | beat_perr;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      commit_q <= last_beat;
    end else begin
      commit_q <= 1'b0;
    end
  end

  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = pkt_vld & pkt_rdy;
  assign push = commit_q & (~full | pop);

  always_ff @(posedge gclk) begin
    if (push) begin
      mem_ctag[wr_ptr] <= stg_ctag;
      mem_data[wr_ptr] <= stg_data;
      mem_rd[wr_ptr]   <= stg_rd;
      mem_ue[wr_ptr]   <= stg_ue;
      mem_par[wr_ptr]  <= stg_par;
    end
  end

  always_ff @(posedge gclk or negedge rst_por_) begin
    if (!rst_por_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovfl_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit_q && full && !pop) ovfl_err <= 1'b1;
    end
  end

  // Head fields are gated by valid so an empty (or just-reset) FIFO presents zeros.
  assign pkt_vld     = (count != '0);
  assign pkt_ctag    = pkt_vld ? mem_ctag[rd_ptr] : '0;
  assign pkt_data    = pkt_vld ? mem_data[rd_ptr] : '0;
  assign pkt_is_rd   = pkt_vld & mem_rd[rd_ptr];
  assign pkt_ue      = pkt_vld & mem_ue[rd_ptr];
  assign pkt_par_err = pkt_vld & mem_par[rd_ptr];
  assign rx_busy     = (state_q == DATA);

endmodule

// File: tb/tb_sio_rx_asm.sv
// tb/tb_sio_rx_asm.sv - scoreboard bench for sio_rx_asm
module tb_sio_rx_asm;
  localparam int BEATS = 16;
  localparam int DW = 32 * BEATS;

  logic          gclk = 1'b0;
  logic          rst_por_;
  logic          l2b_sio_ctag_vld;
  logic [31:0]   l2b_sio_data;
  logic [1:0]    l2b_sio_parity;
  logic          l2b_sio_ue_err;
  logic          pkt_rdy;
  logic          pkt_vld;
  logic [31:0]   pkt_ctag;
  logic [DW-1:0] pkt_data;
  logic          pkt_is_rd, pkt_ue, pkt_par_err, ovfl_err, proto_err, rx_busy;

  typedef struct {
    logic [31:0]   ctag;
    logic [DW-1:0] data;
    logic          rd, ue, par;
  } pkt_t;

  pkt_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  sio_rx_asm #(.DEPTH(2), .BEATS(BEATS)) dut (
    .gclk(gclk), .rst_por_(rst_por_),
    .l2b_sio_ctag_vld(l2b_sio_ctag_vld), .l2b_sio_data(l2b_sio_data),
    .l2b_sio_parity(l2b_sio_parity), .l2b_sio_ue_err(l2b_sio_ue_err),
    .pkt_rdy(pkt_rdy), .pkt_vld(pkt_vld), .pkt_ctag(pkt_ctag), .pkt_data(pkt_data),
    .pkt_is_rd(pkt_is_rd), .pkt_ue(pkt_ue), .pkt_par_err(pkt_par_err),
    .ovfl_err(ovfl_err), .proto_err(proto_err), .rx_busy(rx_busy)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gpar(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] pflip, input logic ue);
    l2b_sio_ctag_vld = v;
    l2b_sio_data     = d;
    l2b_sio_parity   = gpar(d) ^ pflip;
    l2b_sio_ue_err   = ue;
    @(posedge gclk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic push_exp(input logic [31:0] c, input logic [DW-1:0] d,
                          input logic rd, input logic ue, input logic par);
    pkt_t p;
    p.ctag = c; p.data = d; p.rd = rd; p.ue = ue; p.par = par;
    exp_q.push_back(p);
  endtask

  // Header plus n beats of value base+k; flips parity bit0 on beat pb, ue on beat ub.
  task automatic send_read(input logic [31:0] hdr, input int n, input logic [31:0] base,
                           input int pb, input int ub, input bit expect_it);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = base + k;
    if (expect_it) push_exp(hdr, d, 1'b1, ub >= 0, pb >= 0);
    drive(1'b1, hdr, 2'b00, 1'b0);
    for (int k = 0; k < n; k++)
      drive(1'b0, base + k, (k == pb) ? 2'b01 : 2'b00, k == ub);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge gclk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge gclk) begin
    if (rst_por_ && pkt_vld && pkt_rdy) begin
      chk("sb_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        pkt_t p;
        p = exp_q.pop_front();
        chk("ctag", pkt_ctag, p.ctag);
        chk("data", pkt_data, p.data);
        chk("is_rd", pkt_is_rd, p.rd);
        chk("ue", pkt_ue, p.ue);
        chk("par_err", pkt_par_err, p.par);
      end
    end
  end

  initial begin
    rst_por_ = 1'b0;
    pkt_rdy = 1'b1;
    l2b_sio_ctag_vld = 1'b0; l2b_sio_data = '0; l2b_sio_parity = '0; l2b_sio_ue_err = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_vld", pkt_vld, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ovfl", ovfl_err, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_ctag", pkt_ctag, 0);
    @(negedge gclk) rst_por_ = 1'b1;
    @(posedge gclk); #1;

    // write ack, latency T+2
    push_exp(32'h0000_1234, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_1234, 2'b00, 1'b0);
    chk("wr_lat_t1", pkt_vld, 0);
    idle(1);
    chk("wr_lat_t2", pkt_vld, 1);
    idle(2);

    // read, latency T+18
    send_read(32'h0001_00AB, BEATS, 32'h0, -1, -1, 1'b1);
    chk("rd_busy", rx_busy, 0);
    chk("rd_lat_t17", pkt_vld, 0);
    idle(1);
    chk("rd_lat_t18", pkt_vld, 1);
    idle(2);

    // parity on beat 5, ue on beat 9
    send_read(32'h0001_0C00, BEATS, 32'h1000_0000, 5, 9, 1'b1);
    idle(3);
    // header parity error on a write ack
    push_exp(32'h0000_5555, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_5555, 2'b10, 1'b0);
    idle(3);
    drain("drain_basic");

    // full FIFO with same-cycle pop: nothing lost
    pkt_rdy = 1'b0;
    push_exp(32'h0000_0A01, '0, 1'b0, 1'b0, 1'b0);
    push_exp(32'h0000_0A02, '0, 1'b0, 1'b0, 1'b0);
    push_exp(32'h0000_0A03, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0A01, 2'b00, 1'b0);
    drive(1'b1, 32'h0000_0A02, 2'b00, 1'b0);
    drive(1'b1, 32'h0000_0A03, 2'b00, 1'b0);
    pkt_rdy = 1'b1;
    idle(4);
    drain("drain_nolose");
    chk("ovfl_clear", ovfl_err, 0);

    // full FIFO, no pop: third dropped
    pkt_rdy = 1'b0;
    push_exp(32'h0000_0B01, '0, 1'b0, 1'b0, 1'b0);
    push_exp(32'h0000_0B02, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0B01, 2'b00, 1'b0);
    drive(1'b1, 32'h0000_0B02, 2'b00, 1'b0);
    drive(1'b1, 32'h0000_0B03, 2'b00, 1'b0);
    idle(4);
    chk("ovfl_set", ovfl_err, 1);
    chk("ovfl_head", pkt_ctag, 32'h0000_0B01);
    pkt_rdy = 1'b1;
    drain("drain_ovfl");
    idle(2);
    chk("ovfl_empty", pkt_vld, 0);
    chk("ovfl_sticky", ovfl_err, 1);

    // new header at read beat 7
    chk("proto_pre", proto_err, 0);
    send_read(32'h0001_0001, 7, 32'hDEAD_0000, -1, -1, 1'b0);
    send_read(32'h0001_0002, BEATS, 32'h2000_0000, -1, -1, 1'b1);
    chk("proto_set", proto_err, 1);
    drain("drain_proto");

    // async reset mid read with a packet held
    pkt_rdy = 1'b0;
    drive(1'b1, 32'h0000_0777, 2'b00, 1'b0);
    send_read(32'h0001_0003, 10, 32'h3000_0000, -1, -1, 1'b0);
    chk("pre_rst_vld", pkt_vld, 1);
    rst_por_ = 1'b0;
    #2;
    chk("arst_vld", pkt_vld, 0);
    chk("arst_busy", rx_busy, 0);
    chk("arst_ovfl", ovfl_err, 0);
    chk("arst_proto", proto_err, 0);
    chk("arst_ctag", pkt_ctag, 0);
    chk("arst_data", pkt_data, 0);
    exp_q.delete();
    @(negedge gclk) rst_por_ = 1'b1;
    pkt_rdy = 1'b1;
    @(posedge gclk); #1;
    push_exp(32'h0000_0999, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0999, 2'b00, 1'b0);
    chk("post_rst_t1", pkt_vld, 0);
    idle(1);
    chk("post_rst_t2", pkt_vld, 1);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
